// File: rtl/dlsc_axi_cmd_router_pkg.sv
// -----------------------------------------------------------------------------
// dlsc_axi_cmd_router_pkg
// Shared interconnect helpers used by the command router and its decoder.
//   clog2          : ceiling log2 for sizing counters from parameters
//   resp_err_index : position of the decode-error bit in a one-hot destination
//                    vector (the error port sits just above the slave ports)
// -----------------------------------------------------------------------------
package dlsc_axi_cmd_router_pkg;

   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      return r;
   endfunction

   function automatic int resp_err_index(input int outputs);
      return outputs;
   endfunction

endpackage

// File: rtl/dlsc_axi_cmd_router_if.sv
// -----------------------------------------------------------------------------
// dlsc_axi_cmd_router_if
// Bundles the router's command input, slave-port outputs, decode-error port and
// response-mux handshake.
//   slave  : router view (accepts commands, drives ports and resp_sel/busy)
//   master : environment view (upstream source, slaves, response mux)
// -----------------------------------------------------------------------------
interface dlsc_axi_cmd_router_if #(
   parameter int ADDR    = 32,
   parameter int LEN     = 4,
   parameter int OUTPUTS = 2
);
   logic                in_ready;
   logic                in_valid;
   logic [ADDR-1:0]     in_addr;
   logic [LEN-1:0]      in_len;

   logic [OUTPUTS-1:0]  out_ready;
   logic [OUTPUTS-1:0]  out_valid;
   logic [ADDR-1:0]     out_addr;
   logic [LEN-1:0]      out_len;

   logic                err_ready;
   logic                err_valid;
   logic [LEN-1:0]      err_len;

   logic                resp_done;
   logic [OUTPUTS:0]    resp_sel;
   logic                resp_busy;

   modport slave (
      output in_ready,
      input  in_valid, in_addr, in_len,
      input  out_ready,
      output out_valid, out_addr, out_len,
      input  err_ready,
      output err_valid, err_len,
      input  resp_done,
      output resp_sel, resp_busy
   );

   modport master (
      input  in_ready,
      output in_valid, in_addr, in_len,
      output out_ready,
      input  out_valid, out_addr, out_len,
      output err_ready,
      input  err_valid, err_len,
      output resp_done,
      input  resp_sel, resp_busy
   );

endinterface

// File: rtl/dlsc_axi_cmd_router_decoder.sv
// -----------------------------------------------------------------------------
// dlsc_address_decoder
// Combinational address decoder producing a one-hot match over RANGES windows
// plus an error bit.
//   addr_i  : address to decode
//   match_o : one-hot; bit i = window i, bit RANGES = no window matched
// Overlapping windows resolve to the lowest index.
// -----------------------------------------------------------------------------
module dlsc_address_decoder
   import dlsc_axi_cmd_router_pkg::*;
#(
   parameter int                      ADDR   = 32,
   parameter int                      RANGES = 2,
   parameter logic [RANGES*ADDR-1:0]  MASKS  = '0,
   parameter logic [RANGES*ADDR-1:0]  BASES  = '0
) (
   input  logic [ADDR-1:0]  addr_i,
   output logic [RANGES:0]  match_o
);

   localparam int ERR = resp_err_index(RANGES);

   logic hit;

   always_comb begin
      match_o = '0;
      hit     = 1'b0;
      for (int i = 0; i < RANGES; i++) begin
         // MASKS bits are don't-care, so compare only the remaining bits
         if (!hit && ((addr_i & ~MASKS[i*ADDR +: ADDR]) ==
                      (BASES[i*ADDR +: ADDR] & ~MASKS[i*ADDR +: ADDR]))) begin
            match_o[i] = 1'b1;
            hit        = 1'b1;
         end
      end
      match_o[ERR] = !hit;
   end

endmodule

// File: rtl/dlsc_axi_cmd_router.sv
// -----------------------------------------------------------------------------
// dlsc_axi_cmd_router
// Single-slot command router. A command is registered together with its decoded
// one-hot destination, then forwarded to exactly one slave port or to the
// decode-error port. Ordering is kept without IDs: every outstanding command
// targets the same destination, published on resp_sel for the response mux.
//   clk, rst  : clock, asynchronous active-high reset
//   cmd_if    : command in, per-port out, error port, response tracking
// -----------------------------------------------------------------------------
module dlsc_axi_cmd_router
   import dlsc_axi_cmd_router_pkg::*;
#(
   parameter int                       ADDR    = 32,
   parameter int                       LEN     = 4,
   parameter int                       OUTPUTS = 2,
   parameter logic [OUTPUTS*ADDR-1:0]  MASKS   = '0,
   parameter logic [OUTPUTS*ADDR-1:0]  BASES   = '0,
   parameter int                       MOT     = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   dlsc_axi_cmd_router_if.slave   cmd_if
);

   localparam int             CW    = clog2(MOT) + 1;
   localparam int             ERR   = resp_err_index(OUTPUTS);
   localparam logic [CW-1:0]  MOT_C = CW'(MOT);

   logic               slot_valid_q, slot_valid_d;
   logic [ADDR-1:0]    slot_addr_q,  slot_addr_d;
   logic [LEN-1:0]     slot_len_q,   slot_len_d;
   logic [OUTPUTS:0]   slot_match_q, slot_match_d;
   logic [CW-1:0]      count_q,      count_d;
   logic [OUTPUTS:0]   resp_sel_q,   resp_sel_d;

   logic [OUTPUTS:0]   dec_match;
   logic               can_issue;
   logic               issue;
   logic               accept;
   logic               done_ok;

   dlsc_address_decoder #(
      .ADDR   (ADDR),
      .RANGES (OUTPUTS),
      .MASKS  (MASKS),
      .BASES  (BASES)
   ) u_decoder (
      .addr_i  (cmd_if.in_addr),
      .match_o (dec_match)
   );

   // Gating uses only registered state so valids never depend on ready and a
   // blocked slot cannot unblock from a same-cycle resp_done.
   assign can_issue = slot_valid_q && (count_q < MOT_C) &&
                      ((count_q == '0) || (slot_match_q == resp_sel_q));

   assign cmd_if.out_valid = slot_match_q[OUTPUTS-1:0] & {OUTPUTS{can_issue}};
   assign cmd_if.err_valid = can_issue & slot_match_q[ERR];
   assign cmd_if.out_addr  = slot_addr_q;
   assign cmd_if.out_len   = slot_len_q;
   assign cmd_if.err_len   = slot_len_q;

   assign issue = (|(cmd_if.out_valid & cmd_if.out_ready)) |
                  (cmd_if.err_valid & cmd_if.err_ready);

   // Refill in the same cycle the slot drains to sustain one command per cycle.
   assign cmd_if.in_ready = !slot_valid_q || issue;
   assign accept          = cmd_if.in_valid && cmd_if.in_ready;

   // A resp_done with nothing outstanding is dropped.
   assign done_ok = cmd_if.resp_done && (count_q != '0);

   assign cmd_if.resp_sel  = resp_sel_q;
   assign cmd_if.resp_busy = (count_q != '0);

   always_comb begin
      slot_valid_d = slot_valid_q;
      slot_addr_d  = slot_addr_q;
      slot_len_d   = slot_len_q;
      slot_match_d = slot_match_q;
      if (accept) begin
         slot_valid_d = 1'b1;
         slot_addr_d  = cmd_if.in_addr;
         slot_len_d   = cmd_if.in_len;
         slot_match_d = dec_match;
      end else if (issue) begin
         slot_valid_d = 1'b0;
      end
   end

   always_comb begin
      case ({issue, done_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      resp_sel_d = resp_sel_q;
      if (issue) begin
         resp_sel_d = slot_match_q;
      end else if (count_d == '0) begin
         resp_sel_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_valid_q <= 1'b0;
         slot_addr_q  <= '0;
         slot_len_q   <= '0;
         slot_match_q <= '0;
         count_q      <= '0;
         resp_sel_q   <= '0;
      end else begin
         slot_valid_q <= slot_valid_d;
         slot_addr_q  <= slot_addr_d;
         slot_len_q   <= slot_len_d;
         slot_match_q <= slot_match_d;
         count_q      <= count_d;
         resp_sel_q   <= resp_sel_d;
      end
   end

endmodule

// File: tb/tb_dlsc_axi_cmd_router.sv
// -----------------------------------------------------------------------------
// tb_dlsc_axi_cmd_router
// Scoreboard bench: accepted commands are queued with their expected
// destination (from a plain address-range map); a monitor on the falling edge
// compares presented valids/data, in_ready and resp_sel/resp_busy against a
// model of the outstanding commands.
// -----------------------------------------------------------------------------
module tb_dlsc_axi_cmd_router;

   localparam int ADDR    = 32;
   localparam int LEN     = 4;
   localparam int OUTPUTS = 2;
   localparam int MOT     = 4;
   localparam logic [OUTPUTS*ADDR-1:0] BASES = {32'h1000_0000, 32'h0000_0000};
   localparam logic [OUTPUTS*ADDR-1:0] MASKS = {32'h0FFF_FFFF, 32'h0FFF_FFFF};

   typedef struct {
      int               dest;
      logic [ADDR-1:0]  addr;
      logic [LEN-1:0]   len;
   } cmd_t;

   logic clk;
   logic rst;

   dlsc_axi_cmd_router_if #(.ADDR(ADDR), .LEN(LEN), .OUTPUTS(OUTPUTS)) cmd_if ();

   dlsc_axi_cmd_router #(
      .ADDR    (ADDR),
      .LEN     (LEN),
      .OUTPUTS (OUTPUTS),
      .MASKS   (MASKS),
      .BASES   (BASES),
      .MOT     (MOT)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .cmd_if (cmd_if)
   );

   int    checks   = 0;
   int    failures = 0;
   cmd_t  exp_q[$];
   int    m_cnt    = 0;
   int    m_dest   = 0;

   logic [1:0] dir_ready     = 2'b11;
   logic       dir_err_ready = 1'b1;
   logic       rand_mode     = 1'b0;
   logic       drain_mode    = 1'b0;
   int         pulse_req     = 0;
   int         pulse_taken   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Destination by address range: [0,0x1000_0000) port0, next 256MB port1.
   function automatic int ref_dest(input logic [ADDR-1:0] a);
      if (a < 32'h1000_0000) return 0;
      if (a < 32'h2000_0000) return 1;
      return 2;
   endfunction

   // Scoreboard monitor
   int          mn_d;
   logic        mn_can;
   logic        mn_iss;
   logic        mn_rdy;
   logic        mn_done;
   logic [2:0]  mn_exp_v;
   logic [2:0]  mn_exp_sel;
   cmd_t        mn_cmd;

   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         m_cnt = 0;
      end else begin
         mn_exp_sel = (m_cnt != 0) ? 3'(1 << m_dest) : 3'b000;
         chk("resp_busy", 64'(cmd_if.resp_busy), 64'(m_cnt != 0));
         chk("resp_sel", 64'(cmd_if.resp_sel), 64'(mn_exp_sel));
         mn_can = 1'b0;
         mn_d   = 0;
         if (exp_q.size() != 0) begin
            mn_d   = exp_q[0].dest;
            mn_can = (m_cnt < MOT) && ((m_cnt == 0) || (mn_d == m_dest));
         end
         mn_exp_v = mn_can ? 3'(1 << mn_d) : 3'b000;
         chk("valids", 64'({cmd_if.err_valid, cmd_if.out_valid}), 64'(mn_exp_v));
         if (mn_can) begin
            if (mn_d == 2) begin
               chk("err_len", 64'(cmd_if.err_len), 64'(exp_q[0].len));
            end else begin
               chk("out_addr", 64'(cmd_if.out_addr), 64'(exp_q[0].addr));
               chk("out_len", 64'(cmd_if.out_len), 64'(exp_q[0].len));
            end
         end
         mn_iss = mn_can && ((mn_d == 2) ? cmd_if.err_ready : cmd_if.out_ready[mn_d]);
         mn_rdy = (exp_q.size() == 0) || mn_iss;
         chk("in_ready", 64'(cmd_if.in_ready), 64'(mn_rdy));
         if (cmd_if.resp_done && m_cnt == 0)
            chk("resp_done_legal", 64'(cmd_if.resp_done), 64'(0));
         mn_done = cmd_if.resp_done && (m_cnt > 0);
         if (mn_iss) begin
            mn_cmd = exp_q.pop_front();
            m_dest = mn_d;
         end
         m_cnt = m_cnt + (mn_iss ? 1 : 0) - (mn_done ? 1 : 0);
         if (cmd_if.in_valid && mn_rdy) begin
            mn_cmd.dest = ref_dest(cmd_if.in_addr);
            mn_cmd.addr = cmd_if.in_addr;
            mn_cmd.len  = cmd_if.in_len;
            exp_q.push_back(mn_cmd);
         end
      end
   end

   // Sole driver of slave readies and resp_done.
   initial begin
      cmd_if.out_ready = 2'b00;
      cmd_if.err_ready = 1'b0;
      cmd_if.resp_done = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (rand_mode) begin
            cmd_if.out_ready = 2'($urandom);
            cmd_if.err_ready = 1'($urandom);
         end else begin
            cmd_if.out_ready = dir_ready;
            cmd_if.err_ready = dir_err_ready;
         end
         cmd_if.resp_done = 1'b0;
         if (!rst && m_cnt > 0) begin
            if (rand_mode)
               cmd_if.resp_done = ($urandom_range(0, 2) == 0);
            else if (drain_mode)
               cmd_if.resp_done = 1'b1;
            else if (pulse_req != pulse_taken) begin
               cmd_if.resp_done = 1'b1;
               pulse_taken++;
            end
         end
      end
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [ADDR-1:0] a, input logic [LEN-1:0] l);
      logic ok;
      ok = 1'b0;
      cmd_if.in_valid = 1'b1;
      cmd_if.in_addr  = a;
      cmd_if.in_len   = l;
      for (int n = 0; n < 300 && !ok; n++) begin
         @(negedge clk);
         ok = cmd_if.in_ready;
         @(posedge clk);
         #1;
      end
      cmd_if.in_valid = 1'b0;
      cmd_if.in_addr  = ADDR'($urandom);
      cmd_if.in_len   = LEN'($urandom);
      if (!ok) chk("send_timeout", 64'(0), 64'(1));
   endtask

   task automatic drain();
      logic done;
      done          = 1'b0;
      dir_ready     = 2'b11;
      dir_err_ready = 1'b1;
      drain_mode    = 1'b1;
      for (int n = 0; n < 500 && !done; n++) begin
         @(posedge clk);
         #1;
         done = (exp_q.size() == 0) && (m_cnt == 0);
      end
      drain_mode = 1'b0;
      chk("drain_done", 64'(done), 64'(1));
      wait_cycles(2);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_in_ready"},  64'(cmd_if.in_ready),  64'(1));
      chk({tag, "_out_valid"}, 64'(cmd_if.out_valid), 64'(0));
      chk({tag, "_err_valid"}, 64'(cmd_if.err_valid), 64'(0));
      chk({tag, "_resp_busy"}, 64'(cmd_if.resp_busy), 64'(0));
      chk({tag, "_resp_sel"},  64'(cmd_if.resp_sel),  64'(0));
   endtask

   logic [ADDR-1:0] r_addr;
   int              r_pick;

   initial begin
      rst             = 1'b1;
      cmd_if.in_valid = 1'b0;
      cmd_if.in_addr  = '0;
      cmd_if.in_len   = '0;
      wait_cycles(3);
      check_reset_outputs("reset");
      rst = 1'b0;
      wait_cycles(2);

      // single port0 command with completion
      send(32'h0000_0040, 4'd3);
      wait_cycles(2);
      pulse_req++;
      wait_cycles(3);

      // unmatched address to the error port
      send(32'h2000_0000, 4'd5);
      wait_cycles(2);
      pulse_req++;
      wait_cycles(3);

      // destination switch waits for the port0 completion
      send(32'h0000_0100, 4'd1);
      send(32'h1000_0080, 4'd2);
      wait_cycles(4);
      pulse_req++;
      wait_cycles(3);
      pulse_req++;
      wait_cycles(3);

      // MOT limit: fifth command parks in the slot
      for (int i = 0; i < 5; i++) send(32'h0000_0200 + 32'(i * 4), 4'(i));
      wait_cycles(3);
      chk("mot_stall_in_ready", 64'(cmd_if.in_ready), 64'(0));
      chk("mot_stall_busy", 64'(cmd_if.resp_busy), 64'(1));
      pulse_req++;
      wait_cycles(3);
      drain();

      // backpressure on port1 for ten cycles
      dir_ready = 2'b01;
      wait_cycles(2);
      send(32'h1000_0100, 4'd7);
      wait_cycles(10);
      chk("bp_in_ready", 64'(cmd_if.in_ready), 64'(0));
      chk("bp_out_valid", 64'(cmd_if.out_valid), 64'(2'b10));
      dir_ready = 2'b11;
      wait_cycles(2);
      drain();

      // asynchronous reset with three outstanding and a full slot
      for (int i = 0; i < 3; i++) send(32'h0000_0300 + 32'(i * 4), 4'(i + 1));
      wait_cycles(2);
      dir_ready = 2'b00;
      wait_cycles(2);
      send(32'h0000_0400, 4'd4);
      wait_cycles(2);
      chk("pre_rst_in_ready", 64'(cmd_if.in_ready), 64'(0));
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check_reset_outputs("async_rst");
      wait_cycles(2);
      rst = 1'b0;
      dir_ready = 2'b11;
      wait_cycles(2);
      send(32'h1000_0000, 4'd9);
      wait_cycles(3);
      drain();

      // randomized traffic with random readies and completions
      rand_mode = 1'b1;
      for (int i = 0; i < 200; i++) begin
         wait_cycles($urandom_range(0, 2));
         r_pick = $urandom_range(0, 9);
         case (r_pick)
            0:       r_addr = 32'h0FFF_FFFF;
            1:       r_addr = 32'h1000_0000;
            2:       r_addr = 32'h1FFF_FFFF;
            3:       r_addr = 32'h2000_0000;
            default: r_addr = {4'($urandom_range(0, 3)), 28'($urandom)};
         endcase
         send(r_addr, LEN'($urandom));
      end
      rand_mode = 1'b0;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
